// File: rtl/iter_sweep_if.sv
// iter_sweep_if: valid/ready beat bus carrying one sweep index per beat.
// Ports: out_valid/out_val/out_last driven by the sweeper (master), out_ready by the consumer (slave).
// WIDTH must match the WIDTH of the iter_sweep instance it connects to.
interface iter_sweep_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic             out_last;

  modport master (
    output out_valid,
    output out_val,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_val,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/iter_sweep.sv
// iter_sweep: emits every index 0..MAX_VALUE once, in order, as valid/ready beats.
// Latency: first beat valid the cycle after start; done pulses the cycle after the final beat is accepted.
// Backpressure: beats hold stable while out_ready is low; start is ignored while a sweep runs (no queueing).
// Ports: clk, reset_n (async active-low), start, reverse (only with ITER_SWEEP_REVERSE_EN),
//        busy, done, out (iter_sweep_if.master: out_valid, out_ready, out_val, out_last).
// Optional feature: define ITER_SWEEP_REVERSE_EN to add the reverse input (descending sweeps MAX_VALUE..0).
module iter_sweep #(
  parameter int MAX_VALUE = 15,
  parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
`ifdef ITER_SWEEP_REVERSE_EN
  input  logic         reverse,
`endif
  output logic         busy,
  output logic         done,
  iter_sweep_if.master out
);

  localparam logic [WIDTH-1:0] TOP_IDX  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ZERO_IDX = '0;
  localparam logic [WIDTH-1:0] ONE_IDX  = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic             down;        // direction of the sweep in progress, latched at start
  logic             start_down;  // direction requested together with start
  logic [WIDTH-1:0] first_idx;
  logic [WIDTH-1:0] end_idx;
  logic [WIDTH-1:0] next_idx;
  logic             accept;

`ifdef ITER_SWEEP_REVERSE_EN
  assign start_down = reverse;
`else
  assign start_down = 1'b0;
`endif

  assign first_idx = start_down ? TOP_IDX : ZERO_IDX;
  assign end_idx   = down ? ZERO_IDX : TOP_IDX;
  assign next_idx  = down ? (out.out_val - ONE_IDX) : (out.out_val + ONE_IDX);
  assign accept    = out.out_valid && out.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      down          <= 1'b0;
      out.out_valid <= 1'b0;
      out.out_last  <= 1'b0;
      out.out_val   <= ZERO_IDX;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            down          <= start_down;
            out.out_valid <= 1'b1;
            out.out_val   <= first_idx;
            // MAX_VALUE >= 1, so the first index is never the end index.
            out.out_last  <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (out.out_last) begin
              // Final beat taken: back to IDLE, start is only looked at from the next edge on.
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              out.out_valid <= 1'b0;
              out.out_last  <= 1'b0;
              out.out_val   <= ZERO_IDX;
            end else begin
              out.out_val  <= next_idx;
              out.out_last <= (next_idx == end_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
